// File: rtl/alu_op_issuer.sv
// Command-side issuer for the 4-bit ALU/shifter datapath: registers one operation onto
// the datapath, waits a settle window, then returns the captured Res/Of on a response channel.
module alu_op_issuer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_of,
  output logic [WIDTH-1:0] acc,
  output logic             of_sticky,
  input  logic             clr_sticky
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       live;
  logic       accept;
  logic       capture;
  logic       of_cap;

  // Shifter ops leave alu_of floating; the AND with a known 0 keeps X/Z out of the flags.
  function automatic logic mask_of(input logic shifter_op, input logic of_raw);
    mask_of = ~shifter_op & of_raw;
  endfunction

  assign of_cap    = mask_of(alu_mode[3], alu_of);
  assign cmd_ready = live && (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if (state == ISSUE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && live) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath drive: operands change only on accept, so the datapath sees no glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_mode <= 4'd0;
    end else if (accept) begin
      alu_a    <= cmd_use_acc ? acc : cmd_a;
      alu_b    <= cmd_b;
      alu_cin  <= cmd_cin;
      alu_mode <= cmd_mode;
    end
  end

  // Capture stage: result, overflow and accumulator load together at the end of the settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res <= '0;
      rsp_of  <= 1'b0;
      acc     <= '0;
    end else if (capture) begin
      rsp_res <= alu_res;
      rsp_of  <= of_cap;
      acc     <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_sticky <= 1'b0;
    end else if (capture && of_cap) begin
      of_sticky <= 1'b1;
    end else if (clr_sticky) begin
      of_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized bench for alu_op_issuer with a stub datapath and a transaction-level
// reference model compared against every DUT output on each falling edge.
module tb_alu_op_issuer;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_mode = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_cin = 1'b0;
  logic             cmd_use_acc = 1'b0;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_cin;
  logic [3:0]       alu_mode;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_of;
  logic [WIDTH-1:0] acc;
  logic             of_sticky;
  logic             clr_sticky = 1'b0;

  alu_op_issuer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
    .alu_res(alu_res), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_of(rsp_of),
    .acc(acc), .of_sticky(of_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  // Stub datapath: adder with signed overflow, or shift-left with a floating overflow line.
  logic [4:0] stub_sum;
  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
  assign alu_res  = alu_mode[3] ? {alu_a[2:0], 1'b0} : stub_sum[3:0];
  assign alu_of   = alu_mode[3] ? 1'bz
                  : ((alu_a[3] == alu_b[3]) && (stub_sum[3] != alu_a[3]));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  bit rnd_on = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: one outstanding transaction, timed by cycle stamps.
  int  cyc = 0;
  int  m_acc_cyc = 0;
  bit  m_live = 0, m_busy = 0, m_rsp = 0, m_sticky = 0, m_of = 0, m_cin = 0;
  int  m_a = 0, m_b = 0, m_mode = 0, m_res = 0, m_acc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live = 0; m_busy = 0; m_rsp = 0; m_sticky = 0; m_of = 0; m_cin = 0;
      m_a = 0; m_b = 0; m_mode = 0; m_res = 0; m_acc = 0;
    end else begin
      bit accept, cap, hs, cap_of;
      int sa, sb, ssum;
      cyc++;
      accept = m_live && !m_busy && cmd_valid;
      cap    = m_busy && !m_rsp && (cyc == m_acc_cyc + SETTLE);
      hs     = m_rsp && rsp_ready;
      cap_of = 0;
      if (cap) begin
        if (m_mode >= 8) begin
          m_res = (m_a * 2) % 16;
          m_of  = 0;
        end else begin
          sa    = (m_a >= 8) ? m_a - 16 : m_a;
          sb    = (m_b >= 8) ? m_b - 16 : m_b;
          ssum  = sa + sb + m_cin;
          m_res = (m_a + m_b + m_cin) % 16;
          m_of  = (ssum > 7) || (ssum < -8);
        end
        m_acc  = m_res;
        m_rsp  = 1;
        cap_of = m_of;
      end
      if (cap_of) m_sticky = 1;
      else if (clr_sticky) m_sticky = 0;
      if (hs) begin
        m_rsp  = 0;
        m_busy = 0;
      end
      if (accept) begin
        m_a       = cmd_use_acc ? m_acc : int'(cmd_a);
        m_b       = cmd_b;
        m_cin     = cmd_cin;
        m_mode    = cmd_mode;
        m_busy    = 1;
        m_acc_cyc = cyc;
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_ready", cmd_ready, m_live && !m_busy);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_res",   rsp_res,   m_res[7:0]);
      chk("rsp_of",    rsp_of,    m_of);
      chk("acc",       acc,       m_acc[7:0]);
      chk("of_sticky", of_sticky, m_sticky);
      chk("alu_a",     alu_a,     m_a[7:0]);
      chk("alu_b",     alu_b,     m_b[7:0]);
      chk("alu_cin",   alu_cin,   m_cin);
      chk("alu_mode",  alu_mode,  m_mode[7:0]);
    end
  end

  task automatic send(input logic [3:0] mode, input logic [3:0] a, input logic [3:0] b,
                      input logic cin, input logic use_acc);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timeout_fail("send");
    cmd_valid = 1'b1; cmd_mode = mode; cmd_a = a; cmd_b = b;
    cmd_cin = cin; cmd_use_acc = use_acc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_mode = 4'($urandom);
    cmd_cin = 1'($urandom); cmd_use_acc = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) timeout_fail("wait_rsp");
  endtask

  task automatic take(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    wait (rnd_on);
    while (rnd_on) begin
      @(negedge clk);
      clr_sticky = ($urandom_range(0, 7) == 0);
    end
    clr_sticky = 1'b0;
  end

  initial begin
    int lat;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst acc", acc, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst cmd_ready", cmd_ready, 1);

    send(4'b0000, 4'd3, 4'd4, 1'b0, 1'b0);
    chk("add alu_a", alu_a, 8'd3);
    chk("add early rsp_valid", rsp_valid, 0);
    wait_valid(lat);
    chk("add latency", lat, 8'd1);
    chk("add rsp_res", rsp_res, 8'd7);
    chk("add rsp_of", rsp_of, 0);
    chk("add acc", acc, 8'd7);
    take(0);

    send(4'b0000, 4'd7, 4'd1, 1'b0, 1'b0);
    wait_valid(lat);
    chk("ovf rsp_res", rsp_res, 8'd8);
    chk("ovf rsp_of", rsp_of, 1);
    chk("ovf sticky", of_sticky, 1);
    take(0);

    clr_sticky = 1'b1;
    send(4'b0000, 4'd7, 4'd1, 1'b0, 1'b0);
    wait_valid(lat);
    clr_sticky = 1'b0;
    chk("set-wins sticky", of_sticky, 1);
    take(0);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("cleared sticky", of_sticky, 0);

    send(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0);
    wait_valid(lat);
    chk("shift rsp_res", rsp_res, 8'hA);
    chk("shift rsp_of", rsp_of, 0);
    chk("shift sticky", of_sticky, 0);
    take(0);

    send(4'b0000, 4'd3, 4'd4, 1'b0, 1'b0);
    wait_valid(lat);
    take(0);
    send(4'b0000, 4'hF, 4'd2, 1'b1, 1'b1);
    chk("use_acc alu_a", alu_a, 8'd7);
    wait_valid(lat);
    chk("use_acc rsp_res", rsp_res, 8'hA);
    chk("use_acc acc", acc, 8'hA);
    take(0);

    send(4'b0000, 4'd2, 4'd3, 1'b0, 1'b0);
    wait_valid(lat);
    cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd9; cmd_use_acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall rsp_valid", rsp_valid, 1);
      chk("stall rsp_res", rsp_res, 8'd5);
      chk("stall cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    take(0);
    chk("stall alu_a kept", alu_a, 8'd2);

    send(4'b0000, 4'd1, 4'd1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort acc", acc, 0);
    chk("abort sticky", of_sticky, 0);
    chk("abort alu_a", alu_a, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort cmd_ready", cmd_ready, 1);
    chk("abort no rsp", rsp_valid, 0);

    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      wait_valid(lat);
      take($urandom_range(0, 3));
    end
    rnd_on = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
